// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Program memory plus instruction register (IR), sitting directly after the
//   program counter. A fetch copies the PC address into addr_q, reads the
//   program word into the IR one cycle later, and presents it to the control
//   unit with a valid/ack handshake. pc_done strobes for exactly the one READ
//   cycle so the PC advances once per fetched instruction. While idle, a load
//   port can write program words. All state changes on the falling clock edge.
//
// Ports
//   clk          clock, state updates on negedge
//   reset_n      asynchronous reset, active low
//   addr         current PC address
//   fetch_req    control unit requests the next instruction
//   instr_ack    control unit has consumed instr
//   load_en      write load_data to mem[load_addr] (honoured in IDLE only)
//   load_addr    program load address
//   load_data    program load data
//   instr        instruction register contents
//   instr_valid  instr holds an unconsumed instruction
//   pc_done      PC advance strobe (high during READ)
//   fetch_busy   high whenever the unit is not IDLE
//   addr_err     the last fetch addressed a location >= DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fetch_req,
    input  logic              instr_ack,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              pc_done,
    output logic              fetch_busy,
    output logic              addr_err
);

    // Memory index width; DEPTH is assumed to fit in the ADDR_W address space.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic              capture_addr;
    logic              clear_valid;
    logic              mem_we;
    logic              load_in_range;
    logic              read_in_range;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign load_in_range = ({1'b0, load_addr} < DEPTH_L);
    assign read_in_range = ({1'b0, addr_q}    < DEPTH_L);

    assign pc_done    = (state_reg == READ);
    assign fetch_busy = (state_reg != IDLE);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        capture_addr = 1'b0;
        clear_valid  = 1'b0;
        mem_we       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // A load takes priority; a simultaneous fetch is dropped and
                // must be re-presented by the control unit.
                if (load_en) begin
                    mem_we = load_in_range;
                end else if (fetch_req) begin
                    capture_addr = 1'b1;
                    state_next   = READ;
                end
            end
            READ: begin
                state_next = HOLD;
            end
            HOLD: begin
                // Without an ack everything else is ignored so the IR stays put.
                if (instr_ack) begin
                    clear_valid = 1'b1;
                    if (fetch_req) begin
                        capture_addr = 1'b1;
                        state_next   = READ;
                    end else begin
                        state_next   = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address latch and instruction register. addr_q freezes the fetch address
    // because the PC moves on the same edge that loads the IR.
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            if (capture_addr) begin
                addr_q <= addr;
            end
            if (state_reg == READ) begin
                // Out-of-range fetches return a NOP (all zeros) and flag it.
                instr       <= read_in_range ? mem[addr_q[IDX_W-1:0]] : '0;
                addr_err    <= ~read_in_range;
                instr_valid <= 1'b1;
            end else if (clear_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Program memory write port (no reset: contents survive reset)
    // -------------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (mem_we) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Two instances share one stimulus stream: a full 256-word memory and a
//   16-word memory (so that out-of-range fetches can be exercised). A
//   transaction-level reference model tracks program memory, the IR, the
//   valid flag and the fetch phase for each instance and is compared with the
//   DUT outputs after every clock. Inputs change just after the rising edge,
//   the DUT acts on the falling edge, outputs are sampled after the next
//   rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr;
    logic        fetch_req;
    logic        instr_ack;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    logic [15:0] o_instr [2];
    logic        o_valid [2];
    logic        o_pc_done [2];
    logic        o_busy [2];
    logic        o_err [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .reset_n(reset_n), .addr(addr), .fetch_req(fetch_req),
        .instr_ack(instr_ack), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .instr(o_instr[0]), .instr_valid(o_valid[0]),
        .pc_done(o_pc_done[0]), .fetch_busy(o_busy[0]), .addr_err(o_err[0])
    );

    instr_fetch_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .addr(addr), .fetch_req(fetch_req),
        .instr_ack(instr_ack), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .instr(o_instr[1]), .instr_valid(o_valid[1]),
        .pc_done(o_pc_done[1]), .fetch_busy(o_busy[1]), .addr_err(o_err[1])
    );

    // ---------------- reference model ----------------
    // phase: 0 = waiting for a request, 1 = fetching this cycle, 2 = holding
    int          m_depth [2] = '{256, 16};
    int          m_phase [2];
    logic [15:0] m_instr [2];
    logic        m_valid [2];
    logic        m_err [2];
    logic [7:0]  m_addrq [2];
    logic [15:0] m_mem [2][256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_instr[k] = 16'h0;
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            m_addrq[k] = 8'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] == 0) begin
                if (load_en) begin
                    if (int'(load_addr) < m_depth[k]) m_mem[k][load_addr] = load_data;
                end else if (fetch_req) begin
                    m_addrq[k] = addr;
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (int'(m_addrq[k]) < m_depth[k]) begin
                    m_instr[k] = m_mem[k][m_addrq[k]];
                    m_err[k]   = 1'b0;
                end else begin
                    m_instr[k] = 16'h0;
                    m_err[k]   = 1'b1;
                end
                m_valid[k] = 1'b1;
                m_phase[k] = 2;
            end else if (instr_ack) begin
                m_valid[k] = 1'b0;
                m_phase[k] = fetch_req ? 1 : 0;
                if (fetch_req) m_addrq[k] = addr;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s.instr[%0d]", ph, k), 32'(o_instr[k]), 32'(m_instr[k]));
            check_eq($sformatf("%s.valid[%0d]", ph, k), 32'(o_valid[k]), 32'(m_valid[k]));
            check_eq($sformatf("%s.pc_done[%0d]", ph, k), 32'(o_pc_done[k]), 32'(m_phase[k] == 1));
            check_eq($sformatf("%s.busy[%0d]", ph, k), 32'(o_busy[k]), 32'(m_phase[k] != 0));
            check_eq($sformatf("%s.err[%0d]", ph, k), 32'(o_err[k]), 32'(m_err[k]));
        end
    endtask

    // One clock: DUT and model advance on the falling edge, check after rising.
    task automatic tick(input string ph);
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0;
        instr_ack = 1'b0;
        load_en   = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input string ph);
        addr = a; fetch_req = 1'b1;
        tick(ph);
        fetch_req = 1'b0;
        tick(ph);
    endtask

    task automatic ack(input string ph);
        instr_ack = 1'b1;
        tick(ph);
        instr_ack = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        addr      = 8'h0;
        load_addr = 8'h0;
        load_data = 16'h0;
        idle_inputs();

        // Power-on reset (clean falling edge on reset_n)
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Preload every location with random data
        for (int a = 0; a < 256; a++) begin
            load_en = 1'b1; load_addr = 8'(a); load_data = 16'($urandom);
            tick("preload");
        end
        load_en = 1'b0;
        $display("preload done, checks=%0d errors=%0d", checks, errors);

        // Load 0xA5A5@5 and 0x1234@6, then fetch 5
        load_en = 1'b1; load_addr = 8'h05; load_data = 16'hA5A5; tick("t2_load");
        load_addr = 8'h06; load_data = 16'h1234; tick("t3_load");
        load_en = 1'b0;
        addr = 8'h05; fetch_req = 1'b1;
        tick("t2_read");
        check_eq("t2_pc_done_high", 32'(o_pc_done[0]), 32'd1);
        fetch_req = 1'b0;
        tick("t2_hold");
        check_eq("t2_pc_done_low", 32'(o_pc_done[0]), 32'd0);
        check_eq("t2_instr", 32'(o_instr[0]), 32'hA5A5);
        check_eq("t2_valid", 32'(o_valid[0]), 32'd1);
        $display("t2 fetch 0x05 instr=%h", o_instr[0]);

        // Back-to-back: ack with a new request at 6
        instr_ack = 1'b1; fetch_req = 1'b1; addr = 8'h06;
        tick("t3_read");
        check_eq("t3_valid_low", 32'(o_valid[0]), 32'd0);
        check_eq("t3_pc_done", 32'(o_pc_done[0]), 32'd1);
        instr_ack = 1'b0; fetch_req = 1'b0;
        tick("t3_hold");
        check_eq("t3_instr", 32'(o_instr[0]), 32'h1234);
        $display("t3 back-to-back fetch 0x06 instr=%h", o_instr[0]);

        // HOLD without ack: request and load ignored for 10 cycles
        fetch_req = 1'b1; load_en = 1'b1; load_addr = 8'h06; load_data = 16'hFFFF; addr = 8'h05;
        for (int i = 0; i < 10; i++) begin
            tick("t4_hold");
            check_eq("t4_instr_stable", 32'(o_instr[0]), 32'h1234);
        end
        idle_inputs();
        ack("t4_ack");
        fetch(8'h06, "t4_refetch");
        check_eq("t4_mem_unchanged", 32'(o_instr[0]), 32'h1234);
        ack("t4_ack2");
        $display("t4 hold ignores req/load, instr=%h", o_instr[0]);

        // IDLE: load beats a simultaneous request
        load_en = 1'b1; fetch_req = 1'b1; load_addr = 8'h07; load_data = 16'hBEEF; addr = 8'h07;
        tick("t5_load");
        check_eq("t5_no_pc_done", 32'(o_pc_done[0]), 32'd0);
        check_eq("t5_idle", 32'(o_busy[0]), 32'd0);
        idle_inputs();
        fetch(8'h07, "t5_fetch");
        check_eq("t5_instr", 32'(o_instr[0]), 32'hBEEF);
        ack("t5_ack");
        $display("t5 load wins over fetch, instr=%h", o_instr[0]);

        // Out-of-range fetch on the 16-word instance, then an in-range one
        fetch(8'h20, "t6_oor");
        check_eq("t6_oor_instr", 32'(o_instr[1]), 32'h0);
        check_eq("t6_oor_err", 32'(o_err[1]), 32'd1);
        check_eq("t6_full_err", 32'(o_err[0]), 32'd0);
        ack("t6_ack");
        fetch(8'h03, "t6_ok");
        check_eq("t6_ok_err", 32'(o_err[1]), 32'd0);
        ack("t6_ack2");
        $display("t6 addr_err on 0x20 then cleared on 0x03");

        // Asynchronous reset in HOLD, checked before the next clock edge
        fetch(8'h05, "t1_fetch");
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("t1_instr", 32'(o_instr[0]), 32'h0);
        check_eq("t1_valid", 32'(o_valid[0]), 32'd0);
        check_eq("t1_pc_done", 32'(o_pc_done[0]), 32'd0);
        check_eq("t1_busy", 32'(o_busy[0]), 32'd0);
        check_outputs("t1_reset");
        #1 reset_n = 1'b1;
        $display("t1 reset in HOLD clears IR");

        // Asynchronous reset in READ: strobe drops, IR untouched (stays 0)
        addr = 8'h06; fetch_req = 1'b1;
        tick("rr_read");
        fetch_req = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rr_pc_done", 32'(o_pc_done[0]), 32'd0);
        check_outputs("rr_reset");
        #1 reset_n = 1'b1;
        tick("rr_after");
        check_eq("rr_no_ir_update", 32'(o_valid[0]), 32'd0);
        $display("reset in READ suppresses IR update");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            fetch_req = 1'($urandom_range(0, 1));
            instr_ack = 1'($urandom_range(0, 1));
            load_en   = ($urandom_range(0, 4) == 0);
            addr      = 8'($urandom);
            load_addr = 8'($urandom);
            load_data = 16'($urandom);
            tick("rand");
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) ack("drain");
        $display("random phase done, checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
